data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 13 +
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder_dmem_array.sv | 26 ++
 rtl/data_mem_responder.sv | 116 +++++++++++
 tb/tb_data_mem_responder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package data_mem_responder_pkg;
   localparam int DW          = 64;
   localparam int DEF_DEPTH   = 64;
   localparam int DEF_LATENCY = 2;
   localparam int CNT_W       = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;
endpackage

// File: rtl/data_mem_responder_if.sv
// CPU memory-stage request/response bundle; the responder takes the slave side.
interface data_mem_responder_if;
   import data_mem_responder_pkg::*;

   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [DW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          busy;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );
endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// Doubleword storage: single port, synchronous write, combinational read, async clear.
module dmem_array
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [DW-1:0]    wdata,
   output logic [DW-1:0]    rdata
);
   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[idx] <= wdata;
      end
   end

   assign rdata = mem_q[idx];
endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder: latches one request, waits LATENCY cycles,
// commits/reads the array on entering RESP, then holds the response until taken.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic                 clk,
   input  logic                 reset_n,
   data_mem_responder_if.slave  bus
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W:0]   DEPTH_L = (IDX_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             write_q, write_d;
   logic             err_q, err_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [DW-1:0]    wdata_q, wdata_d;
   logic [DW-1:0]    rdata_q, rdata_d;
   logic             rerr_q, rerr_d;

   logic             req_err;
   logic [IDX_W-1:0] req_idx;
   logic             mem_we;
   logic [DW-1:0]    mem_rdata;

   // Anything above the index field, a sub-doubleword offset, or an index past
   // DEPTH (non power-of-two builds) is rejected.
   assign req_idx = bus.req_addr[IDX_W+2:3];
   assign req_err = (bus.req_addr[2:0] != 3'b000)
                  || ((bus.req_addr >> (IDX_W + 3)) != '0)
                  || ({1'b0, req_idx} >= DEPTH_L);

   assign mem_we = (state_q == WAIT) && (cnt_q == '0) && write_q && !err_q;

   dmem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
      .clk   (clk),
      .rst_n (reset_n),
      .we    (mem_we),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      err_d   = err_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      rerr_d  = rerr_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               state_d = WAIT;
               cnt_d   = CNT_INIT;
               write_d = bus.req_write;
               err_d   = req_err;
               idx_d   = req_idx;
               wdata_d = bus.req_wdata;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               rdata_d = (write_q || err_q) ? '0 : mem_rdata;
               rerr_d  = err_q;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
               rdata_d = '0;
               rerr_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         rerr_q  <= rerr_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = rerr_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: the driver queues expected responses, a monitor checks them
// as they appear; two extra builds check the LATENCY=1 and LATENCY=15 timing.
module tb_data_mem_responder;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          acc;
   } exp_t;
   exp_t exp_q[$];

   data_mem_responder_if m();
   data_mem_responder_if a1();
   data_mem_responder_if a15();

   data_mem_responder #(.DEPTH(64), .LATENCY(2))  u_dut   (.clk(clk), .reset_n(reset_n), .bus(m));
   data_mem_responder #(.DEPTH(64), .LATENCY(1))  u_dut1  (.clk(clk), .reset_n(reset_n), .bus(a1));
   data_mem_responder #(.DEPTH(64), .LATENCY(15)) u_dut15 (.clk(clk), .reset_n(reset_n), .bus(a15));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops on each new response, then checks it holds while stalled.
   logic        pv = 1'b0;
   logic [63:0] hold_d;
   logic        hold_e;
   always @(negedge clk) begin
      if (!reset_n) begin
         pv = 1'b0;
      end else begin
         if (m.rsp_valid && !pv) begin
            if (exp_q.size() == 0) begin
               chk("unexpected rsp", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("rsp latency", 64'(cyc - e.acc), 64'd2);
               chk("rsp_rdata",   m.rsp_rdata, e.rdata);
               chk("rsp_err",     64'(m.rsp_err), 64'(e.err));
            end
            hold_d = m.rsp_rdata;
            hold_e = m.rsp_err;
         end else if (m.rsp_valid && pv) begin
            chk("hold rdata",     m.rsp_rdata, hold_d);
            chk("hold err",       64'(m.rsp_err), 64'(hold_e));
            chk("hold req_ready", 64'(m.req_ready), 64'd0);
            chk("hold busy",      64'(m.busy), 64'd1);
         end
         pv = m.rsp_valid;
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (!m.req_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!m.req_ready) chk("req_ready timeout", 64'd0, 64'd1);
   endtask

   task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                      input logic [63:0] er, input logic ee, input int stall, input bit scramble);
      int t = 0;
      @(negedge clk);
      wait_ready();
      m.req_valid = 1'b1;
      m.req_write = w;
      m.req_addr  = a;
      m.req_wdata = d;
      m.rsp_ready = (stall == 0);
      @(posedge clk);
      #1;
      exp_q.push_back('{er, ee, cyc});
      @(negedge clk);
      m.req_valid = 1'b0;
      while (!m.rsp_valid && t < 40) begin
         if (scramble) begin
            m.req_addr  = {$urandom, $urandom};
            m.req_wdata = {$urandom, $urandom};
            m.req_write = ~m.req_write;
         end
         @(negedge clk);
         t++;
      end
      if (!m.rsp_valid) begin
         chk("rsp timeout", 64'd0, 64'd1);
         m.rsp_ready = 1'b1;
         return;
      end
      for (int i = 1; i < stall; i++) @(negedge clk);
      m.rsp_ready = 1'b1;
      @(negedge clk);
      chk("post req_ready", 64'(m.req_ready), 64'd1);
      chk("post rsp_valid", 64'(m.rsp_valid), 64'd0);
      chk("post rsp_rdata", m.rsp_rdata, 64'd0);
      chk("post busy",      64'(m.busy), 64'd0);
   endtask

   // Drives the LATENCY=1 and LATENCY=15 builds together and times each response.
   task automatic lat_txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                          input logic [63:0] er);
      int t = 0;
      int t1 = -1;
      int t15 = -1;
      int acc;
      @(negedge clk);
      while (!(a1.req_ready && a15.req_ready) && t < 40) begin
         @(negedge clk);
         t++;
      end
      a1.req_valid = 1'b1;  a1.req_write = w;  a1.req_addr = a;  a1.req_wdata = d;
      a15.req_valid = 1'b1; a15.req_write = w; a15.req_addr = a; a15.req_wdata = d;
      @(posedge clk);
      #1;
      acc = cyc;
      @(negedge clk);
      a1.req_valid = 1'b0;
      a15.req_valid = 1'b0;
      t = 0;
      while ((t1 < 0 || t15 < 0) && t < 40) begin
         if (a1.rsp_valid && t1 < 0) begin
            t1 = cyc - acc;
            chk("lat1 rdata", a1.rsp_rdata, er);
         end
         if (a15.rsp_valid && t15 < 0) begin
            t15 = cyc - acc;
            chk("lat15 rdata", a15.rsp_rdata, er);
         end
         @(negedge clk);
         t++;
      end
      chk("lat1 cycles",  64'(t1),  64'd1);
      chk("lat15 cycles", 64'(t15), 64'd15);
   endtask

   initial begin
      m.req_valid = 1'b0;  m.req_write = 1'b0;  m.req_addr = '0;  m.req_wdata = '0;  m.rsp_ready = 1'b1;
      a1.req_valid = 1'b0; a1.req_write = 1'b0; a1.req_addr = '0; a1.req_wdata = '0; a1.rsp_ready = 1'b1;
      a15.req_valid = 1'b0; a15.req_write = 1'b0; a15.req_addr = '0; a15.req_wdata = '0; a15.rsp_ready = 1'b1;

      repeat (3) @(negedge clk);
      chk("reset req_ready", 64'(m.req_ready), 64'd1);
      chk("reset rsp_valid", 64'(m.rsp_valid), 64'd0);
      chk("reset rsp_rdata", m.rsp_rdata, 64'd0);
      chk("reset rsp_err",   64'(m.rsp_err), 64'd0);
      chk("reset busy",      64'(m.busy), 64'd0);
      reset_n = 1'b1;

      // store/load round trip, error accesses, and array untouched by errors
      txn(1'b1, 64'h10,  64'hDEADBEEF_00000001, 64'h0, 1'b0, 0, 1'b0);
      txn(1'b0, 64'h10,  64'h0, 64'hDEADBEEF_00000001, 1'b0, 0, 1'b0);
      txn(1'b1, 64'h0,   64'h1111, 64'h0, 1'b0, 0, 1'b0);
      txn(1'b1, 64'h200, 64'hBAD,  64'h0, 1'b1, 0, 1'b0);
      txn(1'b0, 64'h0,   64'h0, 64'h1111, 1'b0, 0, 1'b0);
      txn(1'b0, 64'h13,  64'h0, 64'h0, 1'b1, 0, 1'b0);
      txn(1'b0, 64'h200, 64'h0, 64'h0, 1'b1, 0, 1'b0);
      txn(1'b1, 64'h11,  64'h999, 64'h0, 1'b1, 0, 1'b0);
      txn(1'b1, 64'h8000_0000_0000_0010, 64'h777, 64'h0, 1'b1, 0, 1'b0);
      txn(1'b0, 64'h10,  64'h0, 64'hDEADBEEF_00000001, 1'b0, 0, 1'b0);

      // response held under back-pressure
      txn(1'b0, 64'h10,  64'h0, 64'hDEADBEEF_00000001, 1'b0, 5, 1'b0);

      // request bus churning during WAIT; top index
      txn(1'b1, 64'h1F8, 64'hCAFE_F00D_1234_5678, 64'h0, 1'b0, 0, 1'b1);
      txn(1'b0, 64'h1F8, 64'h0, 64'hCAFE_F00D_1234_5678, 1'b0, 0, 1'b1);

      // reset pulsed in WAIT drops the pending store and clears the array
      txn(1'b1, 64'h8, 64'h77, 64'h0, 1'b0, 0, 1'b0);
      txn(1'b0, 64'h8, 64'h0, 64'h77, 1'b0, 0, 1'b0);
      @(negedge clk);
      wait_ready();
      m.req_valid = 1'b1; m.req_write = 1'b1; m.req_addr = 64'h8; m.req_wdata = 64'h55;
      @(posedge clk);
      @(negedge clk);
      m.req_valid = 1'b0;
      chk("wait busy", 64'(m.busy), 64'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("rst req_ready", 64'(m.req_ready), 64'd1);
      chk("rst rsp_valid", 64'(m.rsp_valid), 64'd0);
      chk("rst rsp_rdata", m.rsp_rdata, 64'd0);
      chk("rst rsp_err",   64'(m.rsp_err), 64'd0);
      chk("rst busy",      64'(m.busy), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      txn(1'b0, 64'h8,   64'h0, 64'h0, 1'b0, 0, 1'b0);
      txn(1'b0, 64'h1F8, 64'h0, 64'h0, 1'b0, 0, 1'b0);

      // latency extremes, back-to-back
      lat_txn(1'b1, 64'h18, 64'hABC, 64'h0);
      lat_txn(1'b0, 64'h18, 64'h0, 64'hABC);
      lat_txn(1'b0, 64'h18, 64'h0, 64'hABC);

      repeat (3) @(negedge clk);
      chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
